controle_dispensa: RTL and testbench

- Responder to the digit-entry controller. Accepts a completed row/column selection, checks stock and credit, runs the dispense motor, reports debit and change, then returns the OK pulse that releases the digit controller from its blocked state.
- Sits between the keypad digit logic and the coin/credit and motor driver blocks.
- Price is obtained from an external combinational price table addressed by this block.

---
 rtl/controle_dispensa.sv | 99 +++++++++
 tb/tb_controle_dispensa.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/controle_dispensa.sv
// Dispense controller: validates a row/column selection against stock and credit,
// drives the motor line, reports debit/change, then releases the digit controller with OK.
module controle_dispensa #(
  parameter int TEMPO_MOTOR = 50,
  parameter int TEMPO_ERRO  = 20,
  parameter int W_CREDITO   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 selecaoPronta,
  input  logic [1:0]           linha,
  input  logic [1:0]           coluna,
  input  logic [W_CREDITO-1:0] credito,
  input  logic [W_CREDITO-1:0] preco,
  input  logic [15:0]          estoque,
  output logic [3:0]           enderecoProduto,
  output logic [15:0]          motor,
  output logic [W_CREDITO-1:0] debito,
  output logic                 debitoValido,
  output logic [W_CREDITO-1:0] troco,
  output logic                 trocoValido,
  output logic                 semEstoque,
  output logic                 creditoInsuficiente,
  output logic                 OK,
  output logic                 ocupado
);
  localparam int TMAX = (TEMPO_MOTOR > TEMPO_ERRO) ? TEMPO_MOTOR : TEMPO_ERRO;
  localparam int CW   = $clog2(TMAX + 1);

  typedef enum logic [2:0] {ESPERA, CONSULTA, VALIDA, DISPENSA, TROCO, ERRO, CONCLUI} estado_t;

  estado_t              estado;
  logic [CW-1:0]        cnt;
  logic [W_CREDITO-1:0] precoReg, trocoReg;
  logic                 erroEstoque;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado          <= ESPERA;
      cnt             <= '0;
      enderecoProduto <= '0;
      precoReg        <= '0;
      trocoReg        <= '0;
      debito          <= '0;
      troco           <= '0;
      erroEstoque     <= 1'b0;
    end else begin
      case (estado)
        ESPERA: if (selecaoPronta) begin
          enderecoProduto <= {linha, coluna};
          estado          <= CONSULTA;
        end
        CONSULTA: estado <= VALIDA;
        VALIDA: begin
          // stock failure wins over a credit failure
          if (!estoque[enderecoProduto]) begin
            erroEstoque <= 1'b1;
            cnt         <= CW'(TEMPO_ERRO);
            estado      <= ERRO;
          end else if (credito < preco) begin
            erroEstoque <= 1'b0;
            cnt         <= CW'(TEMPO_ERRO);
            estado      <= ERRO;
          end else begin
            precoReg <= preco;
            trocoReg <= credito - preco;
            cnt      <= CW'(TEMPO_MOTOR);
            estado   <= DISPENSA;
          end
        end
        DISPENSA: begin
          if (cnt == CW'(1)) begin
            // debit/change outputs only move here so they hold between transactions
            debito <= precoReg;
            troco  <= trocoReg;
            estado <= TROCO;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        TROCO: estado <= CONCLUI;
        ERRO: begin
          if (cnt == CW'(1)) estado <= CONCLUI;
          else               cnt    <= cnt - CW'(1);
        end
        CONCLUI: estado <= ESPERA;
        default: estado <= ESPERA;
      endcase
    end
  end

  assign motor               = (estado == DISPENSA) ? (16'b1 << enderecoProduto) : 16'h0000;
  assign debitoValido        = (estado == TROCO);
  assign trocoValido         = (estado == TROCO) && (trocoReg != '0);
  assign semEstoque          = (estado == ERRO) && erroEstoque;
  assign creditoInsuficiente = (estado == ERRO) && !erroEstoque;
  assign OK                  = (estado == CONCLUI);
  assign ocupado             = (estado != ESPERA);
endmodule

// File: tb/tb_controle_dispensa.sv
// Bench for controle_dispensa: directed plan cases plus random transactions checked
// cycle by cycle against a timeline model derived from the transaction outcome.
module tb_controle_dispensa;
  localparam int TM = 4;
  localparam int TE = 5;
  localparam int W  = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         selecaoPronta = 1'b0;
  logic [1:0]   linha = '0, coluna = '0;
  logic [W-1:0] credito = '0, preco;
  logic [15:0]  estoque = '0;
  logic [3:0]   enderecoProduto;
  logic [15:0]  motor;
  logic [W-1:0] debito, troco;
  logic         debitoValido, trocoValido, semEstoque, creditoInsuficiente, OK, ocupado;

  logic [W-1:0] priceTab [16];
  assign preco = priceTab[enderecoProduto];

  controle_dispensa #(.TEMPO_MOTOR(TM), .TEMPO_ERRO(TE), .W_CREDITO(W)) dut (
    .clk(clk), .rst_n(rst_n), .selecaoPronta(selecaoPronta), .linha(linha), .coluna(coluna),
    .credito(credito), .preco(preco), .estoque(estoque), .enderecoProduto(enderecoProduto),
    .motor(motor), .debito(debito), .debitoValido(debitoValido), .troco(troco),
    .trocoValido(trocoValido), .semEstoque(semEstoque), .creditoInsuficiente(creditoInsuficiente),
    .OK(OK), .ocupado(ocupado)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0]  motor;
    logic [3:0]   addr;
    logic         debV;
    logic [W-1:0] deb;
    logic         troV;
    logic [W-1:0] tro;
    logic         semE;
    logic         credI;
    logic         ok;
    logic         ocup;
  } obs_t;

  obs_t obs;
  assign obs = '{motor: motor, addr: enderecoProduto, debV: debitoValido, deb: debito,
                 troV: trocoValido, tro: troco, semE: semEstoque, credI: creditoInsuficiente,
                 ok: OK, ocup: ocupado};

  int checks = 0;
  int errors = 0;
  int txn = 0;
  logic [W-1:0] hDeb = '0, hTro = '0;  // model of the held debit/change values

  task automatic check(input string tag, input obs_t e);
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, e);
    end
  endtask

  task automatic checkBit(input string tag, input logic o, input logic e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s obs=%b exp=%b", tag, o, e);
    end
  endtask

  // Called at a falling edge; that cycle is cycle 0 of the transaction.
  task automatic tx(input logic [1:0] l, input logic [1:0] c, input logic [W-1:0] cr,
                    input logic [15:0] est, input logic [W-1:0] pr, input bit retrig,
                    input bit lateTrig);
    logic [3:0] a;
    bit inStock, enough, good;
    int okCyc, last;
    obs_t e;
    a = {l, c};
    priceTab[a] = pr;
    inStock = est[a];
    enough  = (cr >= pr);
    good    = inStock && enough;
    okCyc   = good ? 4 + TM : 3 + TE;
    last    = okCyc + 1;
    linha = l; coluna = c; credito = cr; estoque = est; selecaoPronta = 1'b1;
    txn++;
    for (int cy = 1; cy <= last; cy++) begin
      @(negedge clk);
      selecaoPronta = 1'b0;
      if (retrig && cy == 4) begin
        selecaoPronta = 1'b1; linha = ~l; coluna = ~c;
      end
      if (lateTrig && cy == okCyc) begin
        selecaoPronta = 1'b1; linha = ~l; coluna = c;
      end
      if (good && cy == 3 + TM) begin
        hDeb = pr;
        hTro = cr - pr;
      end
      e       = '0;
      e.addr  = a;
      e.deb   = hDeb;
      e.tro   = hTro;
      e.ocup  = (cy < last);
      e.motor = (good && cy >= 3 && cy <= 2 + TM) ? (16'h1 << a) : 16'h0;
      e.debV  = good && cy == 3 + TM;
      e.troV  = good && cy == 3 + TM && (cr != pr);
      e.semE  = !inStock && cy >= 3 && cy <= 2 + TE;
      e.credI = inStock && !enough && cy >= 3 && cy <= 2 + TE;
      e.ok    = (cy == okCyc);
      check($sformatf("tx%0d_c%0d", txn, cy), e);
      // after VALIDA the inputs must no longer matter
      if (cy >= 3 && cy < last) begin
        credito = W'($urandom);
        estoque = 16'($urandom);
        priceTab[a] = W'($urandom);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) priceTab[i] = W'(10 * i);
    #3;
    check("reset", '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // success with change, out of stock, insufficient credit, both failures, exact credit
    tx(2'd2, 2'd1, 8'd100, 16'hFFFF, 8'd75, 0, 0);
    tx(2'd2, 2'd1, 8'd100, 16'hFDFF, 8'd75, 0, 0);
    tx(2'd2, 2'd1, 8'd50,  16'hFFFF, 8'd75, 0, 0);
    tx(2'd2, 2'd1, 8'd50,  16'hFDFF, 8'd75, 0, 0);
    tx(2'd0, 2'd3, 8'd60,  16'hFFFF, 8'd60, 0, 0);
    // free product, ignored re-triggers, selection during CONCLUI
    tx(2'd3, 2'd3, 8'd0,   16'h8000, 8'd0,  0, 0);
    tx(2'd1, 2'd2, 8'd200, 16'hFFFF, 8'd1,  1, 1);
    tx(2'd1, 2'd0, 8'd200, 16'h0000, 8'd1,  1, 1);
    tx(2'd0, 2'd0, 8'd255, 16'h0001, 8'd255, 0, 0);

    for (int n = 0; n < 40; n++) begin
      logic [W-1:0] pr, cr;
      pr = W'($urandom);
      case ($urandom_range(0, 3))
        0:       cr = pr;
        1:       cr = W'($urandom);
        2:       cr = (pr > 8'd200) ? pr : pr + W'($urandom_range(1, 50));
        default: cr = '0;
      endcase
      tx(2'($urandom), 2'($urandom), cr, 16'($urandom), pr,
         $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
    end

    // asynchronous reset in the second DISPENSA cycle
    linha = 2'd2; coluna = 2'd1; credito = 8'd100; estoque = 16'hFFFF; priceTab[9] = 8'd75;
    selecaoPronta = 1'b1;
    @(negedge clk);
    selecaoPronta = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2;
    check("pre_reset_dispensa", '{motor: 16'h0200, addr: 4'd9, debV: 1'b0, deb: hDeb,
                                  troV: 1'b0, tro: hTro, semE: 1'b0, credI: 1'b0,
                                  ok: 1'b0, ocup: 1'b1});
    rst_n = 1'b0;
    #1;
    checkBit("async_motor_zero", motor == 16'h0, 1'b1);
    checkBit("async_ocupado", ocupado, 1'b0);
    hDeb = '0; hTro = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int cy = 0; cy < 8; cy++) begin
      @(negedge clk);
      check($sformatf("post_reset_c%0d", cy), '0);
    end

    // a fresh transaction still works after the reset
    tx(2'd2, 2'd1, 8'd100, 16'hFFFF, 8'd75, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
